// File: rtl/layer7_weight_ctrl.sv
// Layer-7 weight memory sequencer: writes one full 400-word weight image from a
// valid/ready stream, then sweeps the shared dual-port read rows on command.
module layer7_weight_ctrl #(
    parameter int WORDS_PER_ROW = 8,
    parameter int NUM_ROWS      = 50,
    parameter int READ_ROWS     = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [15:0] wdata_in,
    input  logic        wvalid_in,
    output logic        wready_out,
    output logic        write_weight_signal,
    output logic [15:0] write_weight_data,
    output logic [15:0] write_weight_addr,
    input  logic        compute_start,
    input  logic        compute_stall,
    output logic        read_weight_signal,
    output logic [15:0] read_weight_addr1,
    output logic [15:0] read_weight_addr2,
    output logic        rd_valid,
    output logic        load_done,
    output logic        compute_done,
    output logic        weights_loaded,
    output logic        cmd_err,
    output logic        busy
);

    localparam int NUM_WORDS = WORDS_PER_ROW * NUM_ROWS;
    localparam int WCNT_W    = $clog2(NUM_WORDS);
    localparam int RCNT_W    = $clog2(READ_ROWS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_WORDS - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(READ_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [RCNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic                loaded_q, loaded_d;
    logic                load_done_q, load_done_d;
    logic                compute_done_q, compute_done_d;
    logic                cmd_err_q, cmd_err_d;
    logic                rd_valid_q, rd_valid_d;

    logic accept;
    logic issue;
    logic cmd_any;

    assign accept  = (state_q == LOAD) && wvalid_in;
    assign issue   = (state_q == READ) && !compute_stall;
    assign cmd_any = load_start || compute_start;

    // The write port is strobed in the same cycle as the accept, so these stay combinational.
    assign wready_out          = (state_q == LOAD);
    assign write_weight_signal = accept;
    assign write_weight_data   = accept ? wdata_in : 16'd0;
    assign write_weight_addr   = accept ? 16'(word_cnt_q) : 16'd0;

    // DRAIN keeps the read enable high so the last row's data is not gated off.
    assign read_weight_signal = (state_q == READ) || (state_q == DRAIN);
    assign read_weight_addr1  = read_weight_signal ? 16'(row_cnt_q) : 16'd0;
    assign read_weight_addr2  = read_weight_signal ? 16'(row_cnt_q) : 16'd0;

    assign rd_valid       = rd_valid_q;
    assign load_done      = load_done_q;
    assign compute_done   = compute_done_q;
    assign weights_loaded = loaded_q;
    assign cmd_err        = cmd_err_q;
    assign busy           = (state_q != IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        row_cnt_d      = row_cnt_q;
        loaded_d       = loaded_q;
        load_done_d    = 1'b0;
        compute_done_d = 1'b0;
        cmd_err_d      = 1'b0;
        rd_valid_d     = issue;

        unique case (state_q)
            IDLE: begin
                // A load command outranks a simultaneous compute command, which is dropped silently.
                if (load_start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                    loaded_d   = 1'b0;
                end else if (compute_start) begin
                    if (loaded_q) begin
                        state_d   = READ;
                        row_cnt_d = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                cmd_err_d = cmd_any;
                if (accept) begin
                    if (word_cnt_q == WCNT_LAST) begin
                        state_d     = IDLE;
                        word_cnt_d  = '0;
                        load_done_d = 1'b1;
                        loaded_d    = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            READ: begin
                cmd_err_d = cmd_any;
                if (issue) begin
                    if (row_cnt_q == RCNT_LAST) begin
                        state_d        = DRAIN;
                        compute_done_d = 1'b1;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                cmd_err_d = cmd_any;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            word_cnt_q     <= '0;
            row_cnt_q      <= '0;
            loaded_q       <= 1'b0;
            load_done_q    <= 1'b0;
            compute_done_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            row_cnt_q      <= row_cnt_d;
            loaded_q       <= loaded_d;
            load_done_q    <= load_done_d;
            compute_done_q <= compute_done_d;
            cmd_err_q      <= cmd_err_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_layer7_weight_ctrl.sv
// Self-checking bench for layer7_weight_ctrl: a cycle-level behavioural model is
// compared on every cycle, plus hand-computed event timings for each scenario.
module tb_layer7_weight_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] wdata_in = 16'd0;
    logic        wvalid_in = 1'b0;
    logic        compute_start = 1'b0;
    logic        compute_stall = 1'b0;
    logic        wready_out, write_weight_signal, read_weight_signal;
    logic [15:0] write_weight_data, write_weight_addr, read_weight_addr1, read_weight_addr2;
    logic        rd_valid, load_done, compute_done, weights_loaded, cmd_err, busy;

    layer7_weight_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_start          (load_start),
        .wdata_in            (wdata_in),
        .wvalid_in           (wvalid_in),
        .wready_out          (wready_out),
        .write_weight_signal (write_weight_signal),
        .write_weight_data   (write_weight_data),
        .write_weight_addr   (write_weight_addr),
        .compute_start       (compute_start),
        .compute_stall       (compute_stall),
        .read_weight_signal  (read_weight_signal),
        .read_weight_addr1   (read_weight_addr1),
        .read_weight_addr2   (read_weight_addr2),
        .rd_valid            (rd_valid),
        .load_done           (load_done),
        .compute_done        (compute_done),
        .weights_loaded      (weights_loaded),
        .cmd_err             (cmd_err),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Behavioural model of the controller's observable behaviour.
    typedef enum int {M_IDLE, M_LOAD, M_READ, M_DRAIN} m_phase_e;
    m_phase_e m_phase  = M_IDLE;
    int       m_words  = 0;
    int       m_row    = 0;
    bit       m_loaded = 0, m_load_done = 0, m_cmd_err = 0, m_rd_valid = 0;

    // Event recorders filled in by the per-cycle compare.
    int strobe_cnt = 0, first_acc_cyc = -1, load_done_cnt = 0, load_done_cyc = -1;
    int rdv_cnt = 0, rdv_last_cyc = -1, rdv_rise_cnt = 0;
    int rs_rise_cyc = -1, rs_fall_cyc = -1, cdone_cyc = -1, cdone_cnt = 0;
    int cmd_err_cnt = 0, cmd_err_cyc = -1;
    bit prev_rdv = 0, prev_rs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic compare_outputs();
        bit exp_wr, exp_ws, exp_rs;
        exp_wr = (m_phase == M_LOAD);
        exp_ws = exp_wr && wvalid_in;
        exp_rs = (m_phase == M_READ) || (m_phase == M_DRAIN);
        check("wready_out", wready_out, exp_wr);
        check("write_signal", write_weight_signal, exp_ws);
        if (exp_ws) begin
            check("write_addr", write_weight_addr, m_words);
            check("write_data", write_weight_data, wdata_in);
        end else begin
            check("write_data_idle", write_weight_data, 0);
            if (!exp_wr) check("write_addr_idle", write_weight_addr, 0);
        end
        check("read_signal", read_weight_signal, exp_rs);
        if (m_phase == M_READ) begin
            check("read_addr1", read_weight_addr1, m_row);
            check("read_addr2", read_weight_addr2, m_row);
        end else if (!exp_rs) begin
            check("read_addr1_idle", read_weight_addr1, 0);
            check("read_addr2_idle", read_weight_addr2, 0);
        end
        check("rd_valid", rd_valid, m_rd_valid);
        check("load_done", load_done, m_load_done);
        check("compute_done", compute_done, m_phase == M_DRAIN);
        check("weights_loaded", weights_loaded, m_loaded);
        check("cmd_err", cmd_err, m_cmd_err);
        check("busy", busy, m_phase != M_IDLE);

        if (write_weight_signal) begin
            strobe_cnt++;
            if (write_weight_addr == 16'd0) first_acc_cyc = cyc;
        end
        if (load_done) begin load_done_cnt++; load_done_cyc = cyc; end
        if (rd_valid) begin rdv_cnt++; rdv_last_cyc = cyc; if (!prev_rdv) rdv_rise_cnt++; end
        if (read_weight_signal && !prev_rs) rs_rise_cyc = cyc;
        if (!read_weight_signal && prev_rs) rs_fall_cyc = cyc;
        if (compute_done) begin cdone_cnt++; cdone_cyc = cyc; end
        if (cmd_err) begin cmd_err_cnt++; cmd_err_cyc = cyc; end
        prev_rdv = rd_valid;
        prev_rs  = read_weight_signal;
    endtask

    task automatic model_update();
        bit cmd;
        cmd = load_start || compute_start;
        m_load_done = 0;
        m_cmd_err   = 0;
        m_rd_valid  = 0;
        if (rst) begin
            m_phase = M_IDLE; m_words = 0; m_row = 0; m_loaded = 0;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if (load_start) begin
                        m_phase = M_LOAD; m_words = 0; m_loaded = 0;
                    end else if (compute_start) begin
                        if (m_loaded) begin m_phase = M_READ; m_row = 0; end
                        else m_cmd_err = 1;
                    end
                end
                M_LOAD: begin
                    m_cmd_err = cmd;
                    if (wvalid_in) begin
                        if (m_words == 399) begin
                            m_phase = M_IDLE; m_load_done = 1; m_loaded = 1;
                        end else m_words++;
                    end
                end
                M_READ: begin
                    m_cmd_err = cmd;
                    if (!compute_stall) begin
                        m_rd_valid = 1;
                        if (m_row == 24) m_phase = M_DRAIN;
                        else m_row++;
                    end
                end
                default: begin
                    m_cmd_err = cmd;
                    m_phase = M_IDLE;
                end
            endcase
        end
    endtask

    // One clock cycle: compare mid-cycle, advance the model on the edge, return just after it.
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_load(input bit bubble);
        int n, k, s0, d0;
        s0 = strobe_cnt;
        d0 = load_done_cnt;
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        n = 0;
        k = 0;
        while (n < 400) begin
            wvalid_in = bubble ? (k % 2 == 0) : 1'b1;
            wdata_in  = 16'(n);
            cycle();
            if (wvalid_in) n++;
            k++;
        end
        wvalid_in = 1'b0;
        wdata_in  = 16'd0;
        check("ld_pulse_now", load_done, 1);
        check("ld_loaded_now", weights_loaded, 1);
        check("ld_busy_low", busy, 0);
        cycle();
        cycle();
        check("ld_strobe_count", strobe_cnt - s0, 400);
        check("ld_done_count", load_done_cnt - d0, 1);
        check("ld_latency", load_done_cyc - first_acc_cyc, bubble ? 799 : 400);
    endtask

    task automatic do_sweep(input int stall_at, input int stall_len, input int inject_at);
        int t, v0, r0, e0, c0;
        v0 = rdv_cnt; r0 = rdv_rise_cnt; e0 = cmd_err_cnt; c0 = cdone_cnt;
        t = cyc;
        compute_start = 1'b1;
        cycle();
        compute_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            compute_stall = (stall_len > 0) && (k >= stall_at + 1) && (k < stall_at + 1 + stall_len);
            load_start    = (k == inject_at);
            cycle();
        end
        compute_stall = 1'b0;
        load_start    = 1'b0;
        check("sw_first_issue", rs_rise_cyc - t, 1);
        check("sw_done_time", cdone_cyc - t, 26 + stall_len);
        check("sw_done_count", cdone_cnt - c0, 1);
        check("sw_rdv_count", rdv_cnt - v0, 25);
        check("sw_rdv_last", rdv_last_cyc - t, 26 + stall_len);
        check("sw_rdv_bursts", rdv_rise_cnt - r0, stall_len > 0 ? 2 : 1);
        check("sw_rsig_fall", rs_fall_cyc - t, 27 + stall_len);
        check("sw_still_loaded", weights_loaded, 1);
        if (inject_at > 0) begin
            check("sw_err_count", cmd_err_cnt - e0, 1);
            check("sw_err_time", cmd_err_cyc - t, inject_at + 1);
        end else begin
            check("sw_no_err", cmd_err_cnt - e0, 0);
        end
    endtask

    initial begin
        int e0;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_wready", wready_out, 0);
        check("rst_loaded", weights_loaded, 0);
        check("rst_rsig", read_weight_signal, 0);
        check("rst_rdv", rd_valid, 0);
        cycle();

        // Compute before any load is rejected.
        compute_start = 1'b1;
        cycle();
        compute_start = 1'b0;
        check("early_compute_err", cmd_err, 1);
        check("early_compute_idle", busy, 0);
        cycle();
        check("early_compute_err_pulse", cmd_err, 0);

        do_load(1'b0);
        do_sweep(0, 0, 10);
        do_sweep(5, 3, 0);
        do_load(1'b1);

        // Simultaneous commands: load wins without an error.
        e0 = cmd_err_cnt;
        load_start    = 1'b1;
        compute_start = 1'b1;
        cycle();
        load_start    = 1'b0;
        compute_start = 1'b0;
        check("simul_busy", busy, 1);
        check("simul_wready", wready_out, 1);
        check("simul_cleared", weights_loaded, 0);
        for (int n = 0; n < 200; n++) begin
            wvalid_in = 1'b1;
            wdata_in  = 16'(n);
            cycle();
        end
        wvalid_in = 1'b0;
        check("simul_no_err", cmd_err_cnt - e0, 0);

        // Abort the load halfway with reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_wready", wready_out, 0);
        check("abort_loaded", weights_loaded, 0);
        check("abort_wsig", write_weight_signal, 0);
        cycle();

        do_load(1'b0);
        do_sweep(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
